// File: rtl/imm_gen_pipe_pkg.sv
// Shared ISA constants, immediate format codes and pipe state encoding for imm_gen_pipe.
package imm_gen_pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FMT_W   = 3;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [FMT_W-1:0] {
        IMM_FMT_I    = 3'd0,
        IMM_FMT_S    = 3'd1,
        IMM_FMT_B    = 3'd2,
        IMM_FMT_U    = 3'd3,
        IMM_FMT_J    = 3'd4,
        IMM_FMT_Z    = 3'd5,
        IMM_FMT_NONE = 3'd6,
        IMM_FMT_ILL  = 3'd7
    } imm_fmt_e;

    // Occupancy of the main/skid pair: skid is only ever used while main is full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational RV32 immediate decoder: instruction -> (imm, fmt, illegal).
// IMM_GEN_ZICSR_EN enables the CSR zimm format for SYSTEM with funct3 != 0.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm,
    output logic [FMT_W-1:0]   fmt,
    output logic               illegal
);

    logic [31:0] imm32;
    imm_fmt_e    fmt_e;

    always_comb begin
        imm32   = '0;
        fmt_e   = IMM_FMT_ILL;
        illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            illegal = 1'b0;
            case (instr[6:0])
                OPCODE_OPIMM, OPCODE_JALR, OPCODE_LOAD: begin
                    fmt_e = IMM_FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                OPCODE_STORE: begin
                    fmt_e = IMM_FMT_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPCODE_BRANCH: begin
                    fmt_e = IMM_FMT_B;
                    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OPCODE_JAL: begin
                    fmt_e = IMM_FMT_J;
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                OPCODE_LUI, OPCODE_AUIPC: begin
                    fmt_e = IMM_FMT_U;
                    imm32 = {instr[31:12], 12'b0};
                end
                OPCODE_OP: begin
                    fmt_e = IMM_FMT_NONE;
                end
`ifdef IMM_GEN_ZICSR_EN
                OPCODE_SYSTEM: begin
                    if (instr[14:12] != 3'b000) begin
                        fmt_e = IMM_FMT_Z;
                        imm32 = {27'b0, instr[19:15]};
                    end else begin
                        fmt_e = IMM_FMT_I;
                        imm32 = {{20{instr[31]}}, instr[31:20]};
                    end
                end
`endif
                default: begin
                    fmt_e   = IMM_FMT_ILL;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // Zimm has bit 31 clear, so one sign-extending path covers every format.
    assign imm = XLEN'($signed(imm32));
    assign fmt = fmt_e;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry (main + skid) output buffer and flush.
// Build option IMM_GEN_ZICSR_EN (consumed by imm_decode) adds the CSR zimm format.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [FMT_W-1:0]   out_fmt,
    output logic               out_illegal,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    pipe_state_e state, state_nxt;

    logic               in_fire;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    logic [XLEN-1:0]    dec_imm;
    logic [FMT_W-1:0]   dec_fmt;
    logic               dec_illegal;

    logic [XLEN-1:0]    skid_imm;
    logic [FMT_W-1:0]   skid_fmt;
    logic               skid_illegal;
    logic [INSTR_W-1:0] skid_instr;
    logic [XLEN-1:0]    skid_pc;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_fire = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy transitions and data-path load selects; flush beats any transfer.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (out_ready) begin
                        if (in_fire) begin
                            load_main_in = 1'b1;
                        end else begin
                            state_nxt = ST_EMPTY;
                        end
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_MAIN;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake flags registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_nxt != ST_EMPTY);
            in_ready  <= (state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm     <= '0;
            out_fmt     <= IMM_FMT_NONE;
            out_illegal <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
        end else if (load_main_in) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
        end else if (load_main_skid) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_illegal <= skid_illegal;
            out_instr   <= skid_instr;
            out_pc      <= skid_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_imm     <= '0;
            skid_fmt     <= IMM_FMT_NONE;
            skid_illegal <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
        end else if (load_skid) begin
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
        end
    end

endmodule
